// File: rtl/morph_filter_3x3_pkg.sv
// morph_filter_3x3_pkg: shared frame geometry, operator modes and FSM states
package morph_filter_3x3_pkg;
  localparam int X = 320;
  localparam int Y = 240;
  localparam int FRAME_PIXELS = X * Y;
  localparam int MODE_ERODE = 0;
  localparam int MODE_DILATE = 1;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  // erode keeps a pixel only when the whole window is set, dilate when any bit is
  function automatic logic reduce9(input logic [8:0] w, input int mode);
    return mode == MODE_ERODE ? &w : |w;
  endfunction
endpackage

// File: rtl/morph_filter_3x3_raster_window.sv
// raster_window_3x3: 2X+3 bit raster shift window with frame-edge padding
module raster_window_3x3 #(
  parameter int X = morph_filter_3x3_pkg::X,
  parameter int Y = morph_filter_3x3_pkg::Y,
  parameter int MODE = morph_filter_3x3_pkg::MODE_ERODE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift,
  input  logic        clear,
  input  logic        din,
  input  logic        emit,
  input  logic [16:0] col,
  input  logic [16:0] row,
  output logic [8:0]  window,
  output logic        window_valid
);
  import morph_filter_3x3_pkg::*;
  localparam int L = 2 * X + 3;
  localparam logic PAD = MODE == MODE_ERODE;
  logic [L-1:0] sr_q, sr_d, sh;
  // taps are read from the post-shift contents; out-of-frame neighbours take the neutral pad
  always_comb begin
    sh = shift ? {sr_q[L-2:0], din} : sr_q;
    sr_d = clear ? '0 : sh;
    window = {sh[0], sh[1], sh[2], sh[X], sh[X+1], sh[X+2], sh[2*X], sh[2*X+1], sh[2*X+2]};
    if (row == '0) window[2:0] = {3{PAD}};
    if (row == 17'(Y - 1)) window[8:6] = {3{PAD}};
    if (col == '0) {window[6], window[3], window[0]} = {3{PAD}};
    if (col == 17'(X - 1)) {window[8], window[5], window[2]} = {3{PAD}};
    window_valid = shift && emit;
  end
  // window storage, emptied on reset and at the end of every frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr_q <= '0;
    else sr_q <= sr_d;
endmodule

// File: rtl/morph_filter_3x3.sv
// morph_filter_3x3: streaming 3x3 binary erode/dilate over a raster frame
module morph_filter_3x3 #(
  parameter int X = morph_filter_3x3_pkg::X,
  parameter int Y = morph_filter_3x3_pkg::Y,
  parameter int MODE = morph_filter_3x3_pkg::MODE_ERODE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_pixel,
  output logic        out_valid,
  output logic [16:0] out_addr,
  output logic        frame_done
);
  import morph_filter_3x3_pkg::*;
  localparam int FP = X * Y;
  logic [0:0] state_q, state_d;
  logic [16:0] in_idx_q, in_idx_d, flush_q, flush_d, out_cnt_q, out_cnt_d;
  logic [16:0] out_col_q, out_col_d, out_row_q, out_row_d, out_addr_q, out_addr_d;
  logic out_pixel_q, out_pixel_d, out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic flush, accept, last_in, last_flush, emit, shift;
  logic [8:0] win;
  logic win_valid;
  raster_window_3x3 #(.X(X), .Y(Y), .MODE(MODE)) u_win (
    .clk(clk),
    .reset_n(reset_n),
    .shift(shift),
    .clear(last_flush),
    .din(accept & in_pixel),
    .emit(emit),
    .col(out_col_q),
    .row(out_row_q),
    .window(win),
    .window_valid(win_valid)
  );
  // RUN/FLUSH control, input/output raster counters and the registered result
  always_comb begin
    flush = state_q == ST_FLUSH;
    accept = !flush && in_valid;
    last_in = in_idx_q == 17'(FP - 1);
    last_flush = flush && flush_q == 17'(X);
    emit = flush || (accept && in_idx_q >= 17'(X + 1));
    shift = flush || accept;
    in_idx_d = accept ? (last_in ? '0 : in_idx_q + 1'b1) : in_idx_q;
    state_d = accept && last_in ? ST_FLUSH : last_flush ? ST_RUN : state_q;
    flush_d = flush ? flush_q + 1'b1 : '0;
    out_cnt_d = emit ? (out_cnt_q == 17'(FP - 1) ? '0 : out_cnt_q + 1'b1) : out_cnt_q;
    out_col_d = emit ? (out_col_q == 17'(X - 1) ? '0 : out_col_q + 1'b1) : out_col_q;
    out_row_d = emit && out_col_q == 17'(X - 1) ? (out_row_q == 17'(Y - 1) ? '0 : out_row_q + 1'b1) : out_row_q;
    out_valid_d = win_valid;
    out_pixel_d = win_valid ? reduce9(win, MODE) : out_pixel_q;
    out_addr_d = win_valid ? out_cnt_q : out_addr_q;
    frame_done_d = last_flush;
  end
  // state registers; reset drops any partial frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_RUN;
      in_idx_q <= '0;
      flush_q <= '0;
      out_cnt_q <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      out_addr_q <= '0;
      out_pixel_q <= 1'b0;
      out_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_idx_q <= in_idx_d;
      flush_q <= flush_d;
      out_cnt_q <= out_cnt_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      out_addr_q <= out_addr_d;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  assign in_ready = state_q == ST_RUN;
  assign out_pixel = out_pixel_q;
  assign out_valid = out_valid_q;
  assign out_addr = out_addr_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_morph_filter_3x3.sv
// tb_morph_filter_3x3: scoreboard bench for erode and dilate instances on a reduced frame
module tb_morph_filter_3x3;
  localparam int X = 8;
  localparam int Y = 6;
  localparam int FP = X * Y;
  typedef struct { int kind; int r; int c; int gap; int exp0; int exp1; } vec_t;
  typedef struct { int addr; logic pix; } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_pixel = 1'b0;
  logic in_valid = 1'b0;
  logic rdy0, rdy1, op0, op1, ov0, ov1, fd0, fd1;
  logic [16:0] oa0, oa1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_ov = 0;
  int nrdy = 0;
  int flush_noval = 0;
  int nout [2];
  int ones [2];
  int fdone [2];
  logic rdy_prev = 1'b1;
  logic img [FP];
  exp_t q [2][$];

  morph_filter_3x3 #(.X(X), .Y(Y), .MODE(0)) d0 (
    .clk(clk), .reset_n(reset_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(rdy0),
    .out_pixel(op0), .out_valid(ov0), .out_addr(oa0), .frame_done(fd0));
  morph_filter_3x3 #(.X(X), .Y(Y), .MODE(1)) d1 (
    .clk(clk), .reset_n(reset_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(rdy1),
    .out_pixel(op1), .out_valid(ov1), .out_addr(oa1), .frame_done(fd1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic model(input int m, input int k);
    logic acc, v;
    int r, c, rr, cc;
    acc = m == 0;
    r = k / X;
    c = k % X;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        v = (rr < 0 || rr >= Y || cc < 0 || cc >= X) ? (m == 0) : img[rr * X + cc];
        acc = m == 0 ? (acc & v) : (acc | v);
      end
    return acc;
  endfunction

  task automatic clr();
    for (int m = 0; m < 2; m++) begin
      nout[m] = 0;
      ones[m] = 0;
      fdone[m] = 0;
    end
    nrdy = 0;
    flush_noval = 0;
    t_acc = 0;
    t_ov = 0;
  endtask

  task automatic load(input vec_t v);
    int r, c;
    for (int k = 0; k < FP; k++) begin
      r = k / X;
      c = k % X;
      img[k] = v.kind == 0 ? 1'b0 :
               v.kind == 1 ? 1'b1 :
               v.kind == 2 ? (r == v.r && c == v.c) :
               v.kind == 3 ? (r >= v.r - 1 && r <= v.r + 1 && c >= v.c - 1 && c <= v.c + 1) :
               v.kind == 4 ? !(r == v.r && c == v.c) : 1'($urandom_range(1));
    end
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < FP; k++) q[m].push_back('{addr: k, pix: model(m, k)});
  endtask

  task automatic send_frame(input int gap, input int stop);
    int i, guard;
    logic acc;
    i = 0;
    guard = 0;
    while (i < stop && guard < 20 * FP) begin
      in_valid = $urandom_range(99) >= gap;
      in_pixel = img[i];
      acc = in_valid && rdy0;
      if (acc && i == X + 1) t_acc = cyc;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk("send_count", i, stop);
  endtask

  task automatic finish_frames(input int nf, input int e0, input int e1);
    int t;
    t = 0;
    while ((fdone[0] < nf || fdone[1] < nf) && t < 8 * FP) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_count_m%0d", m), nout[m], nf * FP);
      chk($sformatf("done_count_m%0d", m), fdone[m], nf);
      chk($sformatf("sb_left_m%0d", m), q[m].size(), 0);
    end
    if (e0 >= 0) chk("ones_m0", ones[0], e0);
    if (e1 >= 0) chk("ones_m1", ones[1], e1);
    chk("flush_ready_low_cycles", nrdy, nf * (X + 1));
    chk("flush_without_valid", flush_noval, 0);
    if (nf == 1) chk("first_valid_latency", t_ov - t_acc, 1);
    clr();
  endtask

  task automatic mon(input int m, input logic ov, input logic op, input logic [16:0] oa, input logic fd);
    exp_t e;
    if (fd) begin
      fdone[m]++;
      chk($sformatf("done_addr_m%0d", m), int'(oa), FP - 1);
      chk($sformatf("done_with_valid_m%0d", m), int'(ov), 1);
      if (m == 0) begin
        chk("ready_at_done", int'(rdy0), 1);
        chk("ready_before_done", int'(rdy_prev), 0);
      end
    end
    if (ov) begin
      if (m == 0 && nout[0] == 0) t_ov = cyc;
      nout[m]++;
      ones[m] += int'(op);
      chk($sformatf("sb_has_entry_m%0d", m), int'(q[m].size() > 0), 1);
      if (q[m].size() > 0) begin
        e = q[m].pop_front();
        chk($sformatf("addr_m%0d", m), int'(oa), e.addr);
        chk($sformatf("pix_m%0d_at_%0d", m, e.addr), int'(op), int'(e.pix));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (!rdy0) begin
        nrdy++;
        if (!ov0) flush_noval++;
      end
      mon(0, ov0, op0, oa0, fd0);
      mon(1, ov1, op1, oa1, fd1);
      rdy_prev = rdy0;
    end
  end

  initial begin
    vec_t vt [9];
    vt[0] = '{1, 0, 0, 0, 48, 48};
    vt[1] = '{2, 2, 3, 0, 0, 9};
    vt[2] = '{3, 2, 3, 0, 1, 25};
    vt[3] = '{2, 0, 0, 0, 0, 4};
    vt[4] = '{4, 0, 0, 0, 44, 48};
    vt[5] = '{4, 5, 7, 30, 44, 48};
    vt[6] = '{5, 0, 0, 50, -1, -1};
    vt[7] = '{5, 0, 0, 50, -1, -1};
    vt[8] = '{0, 0, 0, 20, 0, 0};
    clr();
    repeat (2) @(negedge clk);
    chk("rst_ready_m0", int'(rdy0), 1);
    chk("rst_ready_m1", int'(rdy1), 1);
    chk("rst_valid_m0", int'(ov0), 0);
    chk("rst_valid_m1", int'(ov1), 0);
    chk("rst_pixel_m0", int'(op0), 0);
    chk("rst_pixel_m1", int'(op1), 0);
    chk("rst_addr_m0", int'(oa0), 0);
    chk("rst_addr_m1", int'(oa1), 0);
    chk("rst_done_m0", int'(fd0), 0);
    chk("rst_done_m1", int'(fd1), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 9; n++) begin
      load(vt[n]);
      send_frame(vt[n].gap, FP);
      finish_frames(1, vt[n].exp0, vt[n].exp1);
    end
    load(vt[1]);
    send_frame(0, FP);
    load(vt[2]);
    send_frame(0, FP);
    finish_frames(2, 1, 34);
    load(vt[6]);
    send_frame(50, FP / 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(ov0), 0);
    chk("midrst_ready", int'(rdy0), 1);
    chk("midrst_addr", int'(oa1), 0);
    q[0].delete();
    q[1].delete();
    clr();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    load(vt[8]);
    send_frame(0, FP);
    finish_frames(1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
